mem_stage: RTL and testbench

- MEM pipeline stage of the MIPS16 core. Sits between EX and WB.
- Consumes the 38-bit EX/MEM pipeline word that EX produces. Performs data-memory load/store on an internal word-addressed RAM.
- Emits the 37-bit MEM/WB pipeline word and the MEM-stage destination tag used by ID hazard detection.
- After reset, a built-in init sequencer zero-fills the RAM before accepting traffic.

---
 rtl/mem_stage_if.sv | 25 ++
 rtl/mem_stage.sv | 120 ++++++++++++
 tb/tb_mem_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// EX/MEM to MEM/WB pipeline bundle for the MIPS16 MEM stage.
// slave is the MEM stage itself; master is the surrounding pipeline.
interface mem_stage_if;
    logic [37:0] pipeline_reg_in;
    logic [36:0] pipeline_reg_out;
    logic [2:0]  mem_op_dest;
    logic        mem_init_busy;
    logic        mem_addr_err;

    modport master (
        output pipeline_reg_in,
        input  pipeline_reg_out,
        input  mem_op_dest,
        input  mem_init_busy,
        input  mem_addr_err
    );

    modport slave (
        input  pipeline_reg_in,
        output pipeline_reg_out,
        output mem_op_dest,
        output mem_init_busy,
        output mem_addr_err
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS16 MEM stage: word-addressed data RAM, zero-filled after reset, one-cycle MEM/WB register.
// Optional MEM_RANGE_CHECK_EN flags and suppresses accesses beyond DEPTH words.
module mem_stage #(
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ADDR_W = 7
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  pipe_io
);
    localparam logic [0:0] StInit = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    logic [15:0] alu_result;
    logic        mem_write_en;
    logic [15:0] mem_write_data;
    logic        wb_en;
    logic [2:0]  wb_dest;
    logic        wb_mux;
    logic [ADDR_W-1:0] addr;

    assign alu_result     = pipe_io.pipeline_reg_in[37:22];
    assign mem_write_en   = pipe_io.pipeline_reg_in[21];
    assign mem_write_data = pipe_io.pipeline_reg_in[20:5];
    assign wb_en          = pipe_io.pipeline_reg_in[4];
    assign wb_dest        = pipe_io.pipeline_reg_in[3:1];
    assign wb_mux         = pipe_io.pipeline_reg_in[0];
    assign addr           = alu_result[ADDR_W-1:0];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [36:0]       out_q, out_d;
    logic [15:0]       mem_q [DEPTH];

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_wdata;
    logic [15:0]       rd_data;
    logic              oor;
    logic              run;

    assign run = (state_q == StRun);

`ifdef MEM_RANGE_CHECK_EN
    logic err_q;

    assign oor = (|alu_result[15:ADDR_W]) && (mem_write_en || wb_mux);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (run && oor) begin
            err_q <= 1'b1;
        end
    end

    assign pipe_io.mem_addr_err = err_q;
`else
    logic unused_upper;

    assign oor                  = 1'b0;
    assign unused_upper         = ^alu_result[15:ADDR_W];
    assign pipe_io.mem_addr_err = 1'b0;
`endif

    // Write-first: a same-cycle store bypasses the array into the MEM/WB word.
    assign rd_data = oor          ? 16'h0000 :
                     mem_write_en ? mem_write_data : mem_q[addr];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        ram_we    = 1'b0;
        ram_addr  = addr;
        ram_wdata = mem_write_data;
        case (state_q)
            StInit: begin
                ram_we    = 1'b1;
                ram_addr  = cnt_q;
                ram_wdata = 16'h0000;
                cnt_d     = cnt_q + 1'b1;
                out_d     = '0;
                if (cnt_q == LastIdx) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                ram_we = mem_write_en && !oor;
                out_d  = {wb_en, wb_dest, wb_mux, alu_result, rd_data};
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StInit;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    // RAM contents are not reset; the INIT sequencer clears them instead.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[ram_addr] <= ram_wdata;
        end
    end

    assign pipe_io.pipeline_reg_out = out_q;
    assign pipe_io.mem_init_busy    = (state_q == StInit);
    assign pipe_io.mem_op_dest      = (wb_en && run) ? wb_dest : 3'b000;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: init fill, loads/stores, bypass, reset restart.
module tb_mem_stage;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mem_stage_if bus ();

    mem_stage #(
        .DEPTH  (128),
        .ADDR_W (7)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pipe_io (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [36:0] got, input logic [36:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [37:0] mk(input logic [15:0] alu, input logic we,
                                       input logic [15:0] wd, input logic wb,
                                       input logic [2:0] dest, input logic mux);
        return {alu, we, wd, wb, dest, mux};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until busy drops, bounded; also flags any non-zero output seen meanwhile.
    task automatic wait_init(output int n, output logic out_seen);
        n        = 0;
        out_seen = 1'b0;
        while (bus.mem_init_busy && n < 300) begin
            if (bus.pipeline_reg_out != '0) out_seen = 1'b1;
            tick();
            n++;
        end
    endtask

    task automatic load(input logic [15:0] a, input string tag, input logic [15:0] exp);
        bus.pipeline_reg_in = mk(a, 1'b0, 16'h0, 1'b1, 3'd1, 1'b1);
        tick();
        check(tag, bus.pipeline_reg_out, {1'b1, 3'd1, 1'b1, a, exp});
    endtask

    int   n;
    logic seen;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        // A store driven during INIT must be ignored.
        bus.pipeline_reg_in = mk(16'h0003, 1'b1, 16'hDEAD, 1'b1, 3'd5, 1'b1);
        tick();
        rst = 1'b0;
        check("rst_out", bus.pipeline_reg_out, 37'h0);
        check("rst_busy", 37'(bus.mem_init_busy), 37'h1);
        check("rst_err", 37'(bus.mem_addr_err), 37'h0);
        check("init_dest", 37'(bus.mem_op_dest), 37'h0);
        wait_init(n, seen);
        check("init_cycles", 37'(n), 37'd128);
        check("init_out_zero", 37'(seen), 37'h0);
        check("run_busy", 37'(bus.mem_init_busy), 37'h0);

        load(16'h0000, "load0", 16'h0000);
        load(16'h0040, "load64", 16'h0000);
        load(16'h007F, "load127", 16'h0000);
        load(16'h0003, "load3_init_store", 16'h0000);

        bus.pipeline_reg_in = mk(16'h0005, 1'b1, 16'hBEEF, 1'b0, 3'd0, 1'b0);
        tick();
        check("store5", bus.pipeline_reg_out, {1'b0, 3'd0, 1'b0, 16'h0005, 16'hBEEF});
        bus.pipeline_reg_in = mk(16'h0005, 1'b0, 16'h0000, 1'b1, 3'd4, 1'b1);
        #1;
        check("dest_wb1", 37'(bus.mem_op_dest), 37'd4);
        tick();
        check("load5", bus.pipeline_reg_out, {1'b1, 3'd4, 1'b1, 16'h0005, 16'hBEEF});

        bus.pipeline_reg_in = mk(16'h0009, 1'b1, 16'h1234, 1'b1, 3'd4, 1'b1);
        tick();
        check("write_first9", bus.pipeline_reg_out, {1'b1, 3'd4, 1'b1, 16'h0009, 16'h1234});
        bus.pipeline_reg_in = mk(16'h0009, 1'b0, 16'h0000, 1'b0, 3'd4, 1'b1);
        #1;
        check("dest_wb0", 37'(bus.mem_op_dest), 37'd0);
        tick();
        check("reload9", 37'(bus.pipeline_reg_out[15:0]), 37'h1234);

        bus.pipeline_reg_in = mk(16'h00AA, 1'b0, 16'h0000, 1'b1, 3'd2, 1'b0);
        tick();
        check("alu_op", 37'(bus.pipeline_reg_out[36:16]), 37'({1'b1, 3'd2, 1'b0, 16'h00AA}));

        // Reset, then reset again at INIT cycle 50 while a store is driven.
        rst = 1'b1;
        bus.pipeline_reg_in = mk(16'h0003, 1'b1, 16'hCAFE, 1'b1, 3'd6, 1'b1);
        tick();
        rst = 1'b0;
        repeat (50) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_busy", 37'(bus.mem_init_busy), 37'h1);
        wait_init(n, seen);
        check("init2_cycles", 37'(n), 37'd128);
        check("init2_out_zero", 37'(seen), 37'h0);
        load(16'h0003, "load3_after_rst", 16'h0000);
        load(16'h0005, "load5_cleared", 16'h0000);

        bus.pipeline_reg_in = mk(16'h0085, 1'b1, 16'h5555, 1'b0, 3'd0, 1'b0);
        tick();
`ifdef MEM_RANGE_CHECK_EN
        check("oor_rdata", 37'(bus.pipeline_reg_out[15:0]), 37'h0000);
        check("oor_err", 37'(bus.mem_addr_err), 37'h1);
        load(16'h0005, "oor_no_store", 16'h0000);
        check("oor_err_sticky", 37'(bus.mem_addr_err), 37'h1);
`else
        check("wrap_rdata", 37'(bus.pipeline_reg_out[15:0]), 37'h5555);
        check("wrap_err", 37'(bus.mem_addr_err), 37'h0);
        load(16'h0005, "wrap_store", 16'h5555);
        check("wrap_err_after", 37'(bus.mem_addr_err), 37'h0);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst3_err", 37'(bus.mem_addr_err), 37'h0);
        check("rst3_out", bus.pipeline_reg_out, 37'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
